// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: AluOpBus encodings, MEM-stage FSM states and shared constants
package mem_stage_pkg;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [7:0]  EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0]  EXE_ADD_OP = 8'b0010_0000;
   localparam logic [7:0]  EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0]  EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0]  EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0]  EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0]  EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0]  EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0]  EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0]  EXE_SW_OP  = 8'b1110_1011;
   localparam logic [7:0]  EXE_LL_OP  = 8'b1111_0000;
   localparam logic [7:0]  EXE_SC_OP  = 8'b1111_1000;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: big-endian byte-lane steering, store replication, load extension and alignment check
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [7:0]  aluop,
   input  logic [1:0]  addr,
   input  logic [31:0] reg2,
   input  logic [31:0] rdata,
   output logic        mem,
   output logic        we,
   output logic        misalign,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);
   logic bop, hop, wop, sx;
   logic [7:0] b;
   logic [15:0] h;
   always_comb begin
      bop = aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
      hop = aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
      wop = aluop inside {EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP};
      we = aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP};
      sx = aluop inside {EXE_LB_OP, EXE_LH_OP};
      mem = bop | hop | wop;
      misalign = (hop & addr[0]) | (wop & |addr);
      sel = bop ? 4'b1000 >> addr : hop ? (addr[1] ? 4'b0011 : 4'b1100) : wop ? 4'b1111 : 4'b0000;
      wdata = bop ? {4{reg2[7:0]}} : hop ? {2{reg2[15:0]}} : reg2;
      // lane 3 (bits 31:24) sits at byte offset 0
      b = 8'(rdata >> {~addr, 3'b000});
      h = addr[1] ? rdata[15:0] : rdata[31:16];
      ldata = bop ? {{24{sx & b[7]}}, b} : hop ? {{16{sx & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: ToruMIPS MEM stage; ALU pass-through plus request/ack loads and stores with stall and timeout.
// Define LLSC_EN to implement the LLbit with ll/sc semantics; otherwise sc is a nop.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  mem_aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_reg2_i,
   input  logic [4:0]  mem_wd_i,
   input  logic        mem_wreg_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] dbus_rdata_i,
   input  logic        dbus_ack_i,
   output logic [4:0]  wb_wd_o,
   output logic        wb_wreg_o,
   output logic [31:0] wb_wdata_o,
   output logic        stallreq_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_sel_o,
   output logic [31:0] dbus_wdata_o,
   output logic        misalign_o,
   output logic        bus_err_o
);
   state_t state, nxt;
   logic [7:0] cnt, op_q, op;
   logic [31:0] addr_q, reg2_q, hdata, addr, reg2, ldata, wdata;
   logic [4:0] wd_q, hwd, wd;
   logic [3:0] sel;
   logic wreg_q, hwreg, wreg, idle, sc_op, sc_ok, sc_en, go, cmpl, mem, we, mis;
   // while an access is outstanding the op is taken from the issue-time copy
   always_comb begin
      idle = state == S_IDLE;
      op = idle ? mem_aluop_i : op_q;
      addr = idle ? mem_addr_i : addr_q;
      reg2 = idle ? mem_reg2_i : reg2_q;
      wd = idle ? mem_wd_i : wd_q;
      wreg = idle ? mem_wreg_i : wreg_q;
   end
   mem_align u_align (
      .aluop(op), .addr(addr[1:0]), .reg2(reg2), .rdata(dbus_rdata_i),
      .mem(mem), .we(we), .misalign(mis), .sel(sel), .wdata(wdata), .ldata(ldata)
   );
`ifdef LLSC_EN
   logic llbit;
   always_ff @(posedge clk)
      if (rst || flush_i) llbit <= 1'b0;
      else if (cmpl) llbit <= op == EXE_LL_OP ? 1'b1 : sc_op ? 1'b0 : llbit;
   assign sc_ok = llbit;
   assign sc_en = 1'b1;
`else
   assign sc_ok = 1'b0;
   assign sc_en = 1'b0;
`endif
   always_comb begin
      sc_op = op == EXE_SC_OP;
      go = mem & ~mis & ~(sc_op & ~sc_ok);
      nxt = state;
      cmpl = 1'b0;
      dbus_req_o = 1'b0;
      stallreq_o = 1'b0;
      bus_err_o = 1'b0;
      misalign_o = idle & mis;
      wb_wd_o = wd;
      wb_wreg_o = mem ? wreg & ~mis & (sc_op ? sc_en : ~we) : wreg;
      wb_wdata_o = mem ? (sc_op ? {31'b0, sc_ok} : ldata) : mem_wdata_i;
      case (state)
         S_IDLE: if (go) begin
            dbus_req_o = 1'b1;
            cmpl = dbus_ack_i;
            stallreq_o = ~dbus_ack_i;
            nxt = dbus_ack_i ? (stall_i ? S_HOLD : S_IDLE) : S_WAIT;
         end
         S_WAIT: begin
            dbus_req_o = 1'b1;
            cmpl = dbus_ack_i;
            bus_err_o = ~dbus_ack_i & cnt == 8'(TIMEOUT_CYC - 1);
            stallreq_o = ~dbus_ack_i & ~bus_err_o;
            nxt = dbus_ack_i ? (stall_i ? S_HOLD : S_IDLE) : bus_err_o ? S_IDLE : S_WAIT;
            if (bus_err_o) wb_wreg_o = 1'b0;
         end
         default: begin
            wb_wd_o = hwd;
            wb_wreg_o = hwreg;
            wb_wdata_o = hdata;
            if (!stall_i) nxt = S_IDLE;
         end
      endcase
      if (flush_i) begin
         nxt = S_IDLE;
         cmpl = 1'b0;
         dbus_req_o = 1'b0;
         stallreq_o = 1'b0;
         bus_err_o = 1'b0;
         wb_wreg_o = 1'b0;
      end
      if (rst) begin
         nxt = S_IDLE;
         cmpl = 1'b0;
         dbus_req_o = 1'b0;
         stallreq_o = 1'b0;
         bus_err_o = 1'b0;
         misalign_o = 1'b0;
         wb_wd_o = 5'd0;
         wb_wreg_o = 1'b0;
         wb_wdata_o = ZeroWord;
      end
      dbus_we_o = dbus_req_o & we;
      dbus_addr_o = dbus_req_o ? {addr[31:2], 2'b00} : ZeroWord;
      dbus_sel_o = dbus_req_o ? sel : 4'b0000;
      dbus_wdata_o = dbus_req_o ? wdata : ZeroWord;
   end
   always_ff @(posedge clk) begin
      state <= nxt;
      cnt <= state == S_WAIT && nxt == S_WAIT ? cnt + {7'b0, cnt != 8'hFF} : 8'd0;
      if (idle && nxt == S_WAIT) begin
         op_q <= mem_aluop_i;
         addr_q <= mem_addr_i;
         reg2_q <= mem_reg2_i;
         wd_q <= mem_wd_i;
         wreg_q <= mem_wreg_i;
      end
      if (state != S_HOLD && nxt == S_HOLD) begin
         hwd <= wb_wd_o;
         hwreg <= wb_wreg_o;
         hdata <= wb_wdata_o;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage loads, stores, alignment, timeout, hold, flush and ll/sc
`timescale 1ns/1ps
module tb_mem_stage;
   import mem_stage_pkg::*;
   typedef struct packed {logic [4:0] wd; logic wreg; logic [31:0] wdata;} wb_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] mem_aluop_i;
   logic [31:0] mem_addr_i, mem_reg2_i, mem_wdata_i, dbus_rdata_i;
   logic [4:0] mem_wd_i;
   logic mem_wreg_i, stall_i, flush_i, dbus_ack_i;
   logic [4:0] wb_wd_o;
   logic wb_wreg_o, stallreq_o, dbus_req_o, dbus_we_o, misalign_o, bus_err_o;
   logic [31:0] wb_wdata_o, dbus_addr_o, dbus_wdata_o;
   logic [3:0] dbus_sel_o;
   wb_t sb[$];
   int errors = 0, checks = 0, stalls;
   logic f_req, f_we, f_mis, berr;
   logic [3:0] f_sel;
   logic [31:0] f_addr, f_wdata;

   mem_stage #(.TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst), .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i),
      .mem_reg2_i(mem_reg2_i), .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
      .mem_wdata_i(mem_wdata_i), .stall_i(stall_i), .flush_i(flush_i),
      .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .wb_wd_o(wb_wd_o),
      .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o), .stallreq_o(stallreq_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      mem_aluop_i = EXE_NOP_OP;
      mem_addr_i = 32'd0;
      mem_reg2_i = 32'd0;
      mem_wd_i = 5'd0;
      mem_wreg_i = 1'b0;
      mem_wdata_i = 32'd0;
      dbus_rdata_i = 32'd0;
      dbus_ack_i = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [31:0] a, r2, alu, rd, input logic [4:0] wd);
      mem_aluop_i = op;
      mem_addr_i = a;
      mem_reg2_i = r2;
      mem_wdata_i = alu;
      dbus_rdata_i = rd;
      mem_wd_i = wd;
      mem_wreg_i = 1'b1;
   endtask

   // dly = cycles after issue until ack; negative means never ack
   task automatic issue(input string tag, input logic [7:0] op, input logic [31:0] a, r2, alu, rd,
                        input logic [4:0] wd, input int dly, input wb_t e);
      drive(op, a, r2, alu, rd, wd);
      dbus_ack_i = dly == 0;
      sb.push_back(e);
      stalls = 0;
      @(negedge clk);
      {f_req, f_we, f_mis, f_sel, f_addr, f_wdata} = {dbus_req_o, dbus_we_o, misalign_o, dbus_sel_o, dbus_addr_o, dbus_wdata_o};
      while (stallreq_o && stalls < 200) begin
         stalls++;
         step();
         dbus_ack_i = stalls == dly;
         @(negedge clk);
      end
      berr = bus_err_o;
      check({tag, ".wb"}, 64'({wb_wd_o, wb_wreg_o, wb_wdata_o}), 64'(sb.pop_front()));
      step();
      idle_in();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle_in();
      drive(EXE_LW_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd1);
      dbus_ack_i = 1'b1;
      step();
      @(negedge clk);
      check("reset.wb", 64'({wb_wd_o, wb_wreg_o, wb_wdata_o}), 64'd0);
      check("reset.ctl", 64'({stallreq_o, dbus_req_o, dbus_we_o, dbus_sel_o, misalign_o, bus_err_o}), 64'd0);
      check("reset.bus", {dbus_addr_o, dbus_wdata_o}, 64'd0);
      step();
      rst = 1'b0;
      idle_in();

      issue("add", EXE_ADD_OP, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 5'd3, 0, wb_t'{5'd3, 1'b1, 32'h1234_5678});
      check("add.ctl", 64'({f_req, stalls}), 64'd0);

      issue("lb", EXE_LB_OP, 32'h101, 32'h0, 32'hDEAD_BEEF, 32'h1180_2233, 5'd5, 3, wb_t'{5'd5, 1'b1, 32'hFFFF_FF80});
      check("lb.stalls", 64'(stalls), 64'd3);
      check("lb.bus", 64'({f_req, f_we, f_sel, f_addr}), 64'({1'b1, 1'b0, 4'b0100, 32'h100}));
      issue("lbu", EXE_LBU_OP, 32'h101, 32'h0, 32'hDEAD_BEEF, 32'h1180_2233, 5'd5, 0, wb_t'{5'd5, 1'b1, 32'h0000_0080});
      check("lbu.stalls", 64'(stalls), 64'd0);
      issue("lh", EXE_LH_OP, 32'h102, 32'h0, 32'hDEAD_BEEF, 32'h1234_8765, 5'd6, 1, wb_t'{5'd6, 1'b1, 32'hFFFF_8765});
      check("lh.sel", 64'({f_sel, stalls}), 64'({4'b0011, 32'd1}));
      issue("lhu", EXE_LHU_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h8234_8765, 5'd6, 0, wb_t'{5'd6, 1'b1, 32'h0000_8234});
      check("lhu.sel", 64'(f_sel), 64'(4'b1100));
      issue("lw", EXE_LW_OP, 32'h104, 32'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd7, 2, wb_t'{5'd7, 1'b1, 32'hCAFE_F00D});
      check("lw.bus", 64'({f_sel, f_addr, 4'(stalls)}), 64'({4'b1111, 32'h104, 4'd2}));

      issue("sh", EXE_SH_OP, 32'h202, 32'h0000_ABCD, 32'hDEAD_BEEF, 32'h0, 5'd6, 0, wb_t'{5'd6, 1'b0, 32'h0});
      check("sh.bus", 64'({f_req, f_we, f_sel, f_addr}), 64'({1'b1, 1'b1, 4'b0011, 32'h200}));
      check("sh.wdata", 64'(f_wdata), 64'(32'hABCD_ABCD));
      issue("sb", EXE_SB_OP, 32'h103, 32'h1234_565A, 32'hDEAD_BEEF, 32'h0, 5'd2, 1, wb_t'{5'd2, 1'b0, 32'h0});
      check("sb.bus", 64'({f_sel, f_wdata}), 64'({4'b0001, 32'h5A5A_5A5A}));

      issue("mis", EXE_LW_OP, 32'h103, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd7, 0, wb_t'{5'd7, 1'b0, 32'h0});
      check("mis.ctl", 64'({f_mis, f_req, stalls}), 64'({1'b1, 1'b0, 32'd0}));

      issue("tmo", EXE_LW_OP, 32'h108, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd8, -1, wb_t'{5'd8, 1'b0, 32'h0});
      check("tmo.cyc", 64'({berr, stalls}), 64'({1'b1, 32'd64}));
      @(negedge clk);
      check("tmo.idle", 64'({bus_err_o, dbus_req_o, stallreq_o}), 64'd0);
      step();

      // ack under stall_i: result held, bus released, op not reissued
      drive(EXE_LW_OP, 32'h10C, 32'h0, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd9);
      sb.push_back(wb_t'{5'd9, 1'b1, 32'h1357_9BDF});
      @(negedge clk);
      check("hold.wait", 64'({dbus_req_o, stallreq_o}), 64'(2'b11));
      step();
      dbus_ack_i = 1'b1;
      stall_i = 1'b1;
      @(negedge clk);
      check("hold.ack", 64'({stallreq_o, wb_wdata_o}), 64'({1'b0, 32'h1357_9BDF}));
      step();
      dbus_ack_i = 1'b0;
      dbus_rdata_i = 32'h0;
      @(negedge clk);
      check("hold.h1", 64'({dbus_req_o, stallreq_o, wb_wdata_o}), 64'({2'b00, 32'h1357_9BDF}));
      step();
      stall_i = 1'b0;
      @(negedge clk);
      check("hold.req", 64'({dbus_req_o, stallreq_o}), 64'd0);
      check("hold.wb", 64'({wb_wd_o, wb_wreg_o, wb_wdata_o}), 64'(sb.pop_front()));
      step();
      idle_in();
      @(negedge clk);
      check("hold.after", 64'({dbus_req_o, stallreq_o}), 64'd0);
      step();

      drive(EXE_LW_OP, 32'h110, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd10);
      step();
      flush_i = 1'b1;
      @(negedge clk);
      check("flush.same", 64'({dbus_req_o, stallreq_o, wb_wreg_o}), 64'd0);
      step();
      idle_in();
      dbus_ack_i = 1'b1;
      @(negedge clk);
      check("flush.next", 64'({dbus_req_o, stallreq_o, bus_err_o}), 64'd0);
      step();
      idle_in();

      drive(EXE_LW_OP, 32'h114, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd11);
      step();
      @(negedge clk);
      check("rstw.wait", 64'(dbus_req_o), 64'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_in();
      @(negedge clk);
      check("rstw.after", 64'({dbus_req_o, stallreq_o}), 64'd0);
      step();

`ifdef LLSC_EN
      issue("ll", EXE_LL_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h2468_ACE0, 5'd4, 1, wb_t'{5'd4, 1'b1, 32'h2468_ACE0});
      issue("sc", EXE_SC_OP, 32'h100, 32'h77, 32'hDEAD_BEEF, 32'h0, 5'd4, 1, wb_t'{5'd4, 1'b1, 32'h1});
      check("sc.bus", 64'({f_req, f_we, f_wdata}), 64'({2'b11, 32'h77}));
      issue("ll2", EXE_LL_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h1, 5'd4, 0, wb_t'{5'd4, 1'b1, 32'h1});
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      issue("scf", EXE_SC_OP, 32'h100, 32'h77, 32'hDEAD_BEEF, 32'h0, 5'd4, 0, wb_t'{5'd4, 1'b1, 32'h0});
      check("scf.bus", 64'({f_req, stalls}), 64'd0);
`else
      issue("ll", EXE_LL_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h2468_ACE0, 5'd4, 1, wb_t'{5'd4, 1'b1, 32'h2468_ACE0});
      check("ll.bus", 64'({f_req, f_we, f_sel}), 64'({2'b10, 4'b1111}));
      issue("sc", EXE_SC_OP, 32'h100, 32'h77, 32'hDEAD_BEEF, 32'h0, 5'd4, 0, wb_t'{5'd4, 1'b0, 32'h0});
      check("sc.bus", 64'({f_req, stalls}), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ToruMIPS five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It passes ALU results through unchanged and executes loads and stores over a request/acknowledge data bus, with sign/zero extension and byte-lane steering. While a bus access is outstanding it requests a pipeline stall.

## Interface
- TIMEOUT_CYC, default 64: maximum cycles to wait for dbus_ack_i before the access is aborted with bus_err_o.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_aluop_i  in  8  operation from EX/MEM (`AluOpBus` encoding).
- mem_addr_i  in  32  effective address.
- mem_reg2_i  in  32  store data (rt).
- mem_wd_i  in  5  destination register.
- mem_wreg_i  in  1  write enable.
- mem_wdata_i  in  32  ALU result.
- stall_i  in  1  MEM/WB hold from the pipeline controller; high means MEM/WB will not capture this cycle.
- flush_i  in  1  exception flush.
- dbus_rdata_i  in  32  read data, valid with ack.
- dbus_ack_i  in  1  access complete.
- wb_wd_o  out  5  destination register to MEM/WB.
- wb_wreg_o  out  1  write enable to MEM/WB.
- wb_wdata_o  out  32  write data to MEM/WB.
- stallreq_o  out  1  stall request to the controller.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write enable.
- dbus_addr_o  out  32  word address; bits [1:0] are forced to 0.
- dbus_sel_o  out  4  byte lane enables.
- dbus_wdata_o  out  32  write data.
- misalign_o  out  1  address error (AdEL/AdES) for the current op.
- bus_err_o  out  1  timeout abort, one-cycle pulse.

## Operation
- Non-memory ops: wb_* = mem_* combinationally, stallreq_o=0, no bus activity.
- Byte ordering is big-endian. Lane 3 (bits 31:24) is addr[1:0]=0.
  - Byte ops (lb/lbu/sb): sel = 4'b1000 >> addr[1:0].
  - Halfword ops (lh/lhu/sh): sel = 4'b1100 when addr[1]=0, 4'b0011 when addr[1]=1.
  - Word ops (lw/sw): sel = 4'b1111.
- Store data is replicated across lanes: a byte is placed in all four lanes, a halfword in both halves.
- Loads extract the selected lane. lb/lh sign-extend; lbu/lhu zero-extend.
- Stores force wb_wreg_o=0.
- Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - No bus request is issued.
  - misalign_o=1, wb_wreg_o=0, no stall.
- FSM states and transitions:
  - IDLE. On a valid memory op, assert dbus_req_o. If dbus_ack_i is high in the same cycle, the op completes (stallreq_o=0). Otherwise go to WAIT with stallreq_o=1.
  - WAIT. Hold dbus_req_o and the address, sel and data stable. Count cycles.
    - On ack: load data is valid on wb_wdata_o and stallreq_o=0. If stall_i=1, latch the result and go to HOLD; otherwise go to IDLE.
    - When the count reaches TIMEOUT_CYC: pulse bus_err_o, force wb_wreg_o=0, go to IDLE.
  - HOLD. Drive the latched result with no bus request. Return to IDLE on the first cycle with stall_i=0. The held op is never reissued.
- flush_i: from any state, drop dbus_req_o in the same cycle and go to IDLE. A late ack that follows a flush is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0, LLbit 0.
- Zero-wait bus: 0 added cycles.
- N-cycle ack: stallreq_o is high for N cycles, and MEM/WB captures on the edge that ends the ack cycle.
- The timeout counter is 8 bits wide and saturates; it clears on IDLE entry.
- When ack and flush_i occur in the same cycle, flush wins.
- Reset asserted during WAIT aborts the access; dbus_req_o is low on the next cycle.

## Configuration
- LLSC_EN defined:
  - An internal LLbit is implemented.
  - ll behaves as lw and sets LLbit on completion.
  - sc with LLbit=1 performs a sw, writes 1 to rt and clears LLbit.
  - sc with LLbit=0 makes no bus access and writes 0 to rt with no stall.
  - flush_i clears LLbit.
- LLSC_EN undefined: ll decodes as lw, and sc is a nop with wb_wreg_o=0.

## Structure
- The aluop encodings (EXE_LB_OP … EXE_SC_OP), the state encoding and ZeroWord belong in the shared defines package.
- One sub-module, mem_align: purely combinational. It maps op, addr, reg2 and rdata to sel, wdata, extended load data and the misalign flag. The FSM, counter and LLbit stay in mem_stage.

## Test plan
- add result 0x1234_5678 to $3 -> wb_* identical in the same cycle, stallreq_o=0, dbus_req_o=0.
- lb at 0x101 with rdata=0x11_80_22_33 and ack after 3 cycles -> sel=0100, stallreq_o high for 3 cycles, wb_wdata_o=0xFFFF_FF80. lbu -> 0x0000_0080.
- sh at 0x202 with rt=0xABCD -> addr=0x200, sel=0011, wdata=0xABCD_ABCD, wb_wreg_o=0.
- lw at 0x103 -> misalign_o=1, no request, wb_wreg_o=0. No ack for 64 cycles on a valid lw -> bus_err_o pulse, state returns to IDLE.
- Ack while stall_i=1 for 2 cycles -> HOLD keeps the data and dbus_req_o stays low. Flush in WAIT -> dbus_req_o is 0 on the next cycle.
- LLSC_EN: ll then sc -> $rt=1 and a write occurs. ll, flush, sc -> $rt=0 and no bus write.
